dummy_adc_src: RTL and testbench



---
 rtl/dummy_adc_pkg.sv | 28 ++
 rtl/dummy_adc_src_lfsr.sv | 28 ++
 rtl/dummy_adc_src.sv | 136 +++++++++++++
 tb/tb_dummy_adc_src.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dummy_adc_pkg.sv
`default_nettype none
// =============================================================================
// Module      : dummy_adc_pkg
// Description : Shared mode encodings, LFSR constants and sample field widths
//               for the synthetic ADC stream source.
// Revision    : 1.0 - initial release
// =============================================================================
package dummy_adc_pkg;

    typedef enum logic [1:0] {
        MODE_RAMP  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_RSVD  = 2'd3
    } adc_mode_e;

    localparam int          SAMPLE_WIDTH = 32;
    localparam int          LFSR_WIDTH   = 16;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;

    // Galois right-shift step for x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dummy_adc_src_lfsr.sv
`default_nettype none
// =============================================================================
// Module      : dummy_adc_src_lfsr
// Description : 16-bit Galois LFSR with seed load and step enable.
// Revision    : 1.0 - initial release
// =============================================================================
module dummy_adc_src_lfsr
    import dummy_adc_pkg::*;
(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  load,
    input  logic                  step,
    output logic [LFSR_WIDTH-1:0] state
);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= LFSR_SEED;
        end else if (load) begin
            state <= LFSR_SEED;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dummy_adc_src.sv
`default_nettype none
// =============================================================================
// Module      : dummy_adc_src
// Description : AXI4-Stream synthetic ADC sample source (ramp/const/LFSR).
//               Optional DUMMY_ADC_SRC_TIMESTAMP_EN adds a cycle-stamp on tuser.
// Revision    : 1.0 - initial release
// =============================================================================
module dummy_adc_src
    import dummy_adc_pkg::*;
#(
    parameter int C_DATA_WIDTH = 16,
    parameter int C_CNT_WIDTH  = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    ctrl_enable,
    input  logic [1:0]              ctrl_mode,
    input  logic [C_CNT_WIDTH-1:0]  ctrl_period,
    input  logic [C_DATA_WIDTH-1:0] ctrl_step,
    input  logic [C_DATA_WIDTH-1:0] ctrl_const,
    input  logic [C_CNT_WIDTH-1:0]  ctrl_frame_len,
    output logic [C_CNT_WIDTH-1:0]  stat_sample_cnt,
    output logic [C_CNT_WIDTH-1:0]  stat_drop_cnt,
    output logic [31:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
`ifdef DUMMY_ADC_SRC_TIMESTAMP_EN
    output logic [31:0]             m_axis_tuser,
`endif
    output logic                    m_axis_tlast
);

    localparam int c_SEQ_WIDTH = SAMPLE_WIDTH - C_DATA_WIDTH;

    logic [C_CNT_WIDTH-1:0]  r_cnt;
    logic [C_CNT_WIDTH-1:0]  r_frame;
    logic [c_SEQ_WIDTH-1:0]  r_seq;
    logic [C_DATA_WIDTH-1:0] r_ramp;
    logic [LFSR_WIDTH-1:0]   w_lfsr;
    logic [C_CNT_WIDTH-1:0]  w_p_m1;
    logic [C_DATA_WIDTH-1:0] w_data;
    logic                    w_tick;
    logic                    w_hs;
    logic                    w_load;
    logic                    w_drop;
    logic                    w_last;

    // Period 0 and 1 both collapse to a tick every enabled cycle
    assign w_p_m1 = (ctrl_period == '0) ? '0 : (ctrl_period - C_CNT_WIDTH'(1));
    assign w_tick = ctrl_enable && (r_cnt >= w_p_m1);
    assign w_hs   = m_axis_tvalid && m_axis_tready;
    assign w_load = w_tick && (!m_axis_tvalid || m_axis_tready);
    assign w_drop = w_tick && m_axis_tvalid && !m_axis_tready;
    assign w_last = (ctrl_frame_len != '0) &&
                    (r_frame == (ctrl_frame_len - C_CNT_WIDTH'(1)));

    always_comb begin
        w_data = r_ramp;
        case (adc_mode_e'(ctrl_mode))
            MODE_CONST: w_data = ctrl_const;
            MODE_LFSR:  w_data = C_DATA_WIDTH'(w_lfsr);
            default:    w_data = r_ramp;
        endcase
    end

    dummy_adc_src_lfsr u_lfsr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (1'b0),
        .step    (w_tick),
        .state   (w_lfsr)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt  <= '0;
            r_ramp <= '0;
        end else begin
            if (!ctrl_enable || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + C_CNT_WIDTH'(1);
            end
            // Generator state advances on every tick so drops leave gaps in data
            if (w_tick) begin
                r_ramp <= r_ramp + ctrl_step;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid   <= 1'b0;
            m_axis_tdata    <= '0;
            m_axis_tlast    <= 1'b0;
            r_seq           <= '0;
            r_frame         <= '0;
            stat_sample_cnt <= '0;
            stat_drop_cnt   <= '0;
        end else begin
            if (w_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= {r_seq, w_data};
                m_axis_tlast  <= w_last;
                r_seq         <= r_seq + c_SEQ_WIDTH'(1);
                r_frame       <= w_last ? '0 : (r_frame + C_CNT_WIDTH'(1));
            end else if (w_hs) begin
                m_axis_tvalid <= 1'b0;
            end
            if (w_hs) begin
                stat_sample_cnt <= stat_sample_cnt + C_CNT_WIDTH'(1);
            end
            if (w_drop && (stat_drop_cnt != '1)) begin
                stat_drop_cnt <= stat_drop_cnt + C_CNT_WIDTH'(1);
            end
        end
    end

`ifdef DUMMY_ADC_SRC_TIMESTAMP_EN
    logic [31:0] r_ts;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ts         <= '0;
            m_axis_tuser <= '0;
        end else begin
            r_ts <= r_ts + 32'd1;
            if (w_load) begin
                m_axis_tuser <= r_ts;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dummy_adc_src.sv
`default_nettype none
// =============================================================================
// Module      : tb_dummy_adc_src
// Description : Directed self-checking bench for dummy_adc_src.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_dummy_adc_src;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        ctrl_enable;
    logic [1:0]  ctrl_mode;
    logic [31:0] ctrl_period;
    logic [15:0] ctrl_step;
    logic [15:0] ctrl_const;
    logic [31:0] ctrl_frame_len;
    logic [31:0] stat_sample_cnt;
    logic [31:0] stat_drop_cnt;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
`ifdef DUMMY_ADC_SRC_TIMESTAMP_EN
    logic [31:0] m_axis_tuser;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    dummy_adc_src #(.C_DATA_WIDTH(16), .C_CNT_WIDTH(32)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .ctrl_enable     (ctrl_enable),
        .ctrl_mode       (ctrl_mode),
        .ctrl_period     (ctrl_period),
        .ctrl_step       (ctrl_step),
        .ctrl_const      (ctrl_const),
        .ctrl_frame_len  (ctrl_frame_len),
        .stat_sample_cnt (stat_sample_cnt),
        .stat_drop_cnt   (stat_drop_cnt),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
`ifdef DUMMY_ADC_SRC_TIMESTAMP_EN
        .m_axis_tuser    (m_axis_tuser),
`endif
        .m_axis_tlast    (m_axis_tlast)
    );

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    // Leaves the DUT out of reset just after an edge; the next edge is the first active one
    task automatic do_reset();
        aresetn        = 1'b0;
        ctrl_enable    = 1'b0;
        ctrl_mode      = 2'd0;
        ctrl_period    = 32'd0;
        ctrl_step      = 16'd0;
        ctrl_const     = 16'd0;
        ctrl_frame_len = 32'd0;
        m_axis_tready  = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, stat_sample_cnt, stat_drop_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: tvalid=%0b tlast=%0b tdata=%h samp=%0d drop=%0d required all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, stat_sample_cnt, stat_drop_cnt);
        end
    endtask

    task automatic test_ramp();
        logic [31:0] exp;
        do_reset();
        ctrl_mode = 2'd0; ctrl_period = 32'd4; ctrl_step = 16'd3;
        m_axis_tready = 1'b1; ctrl_enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat (3) cyc();
            checks++;
            if (m_axis_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL ramp_gap[%0d]: tvalid=%0b required 0", k, m_axis_tvalid);
            end
            cyc();
            exp = {16'(k), 16'(3 * k)};
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp) begin
                failures++;
                $display("FAIL ramp_sample[%0d]: tvalid=%0b tdata=%h required tvalid=1 tdata=%h",
                         k, m_axis_tvalid, m_axis_tdata, exp);
            end
        end
        checks++;
        if (stat_drop_cnt !== 32'd0) begin
            failures++;
            $display("FAIL ramp_drop: drop=%0d required 0", stat_drop_cnt);
        end
    endtask

    task automatic test_backpressure();
        int held_bad = 0;
        do_reset();
        ctrl_mode = 2'd0; ctrl_period = 32'd0; ctrl_step = 16'd5;
        m_axis_tready = 1'b0; ctrl_enable = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0) held_bad++;
        end
        checks++;
        if (held_bad != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d cycles changed, last tdata=%h required 00000000 held", held_bad, m_axis_tdata);
        end
        checks++;
        if (stat_drop_cnt !== 32'd10) begin
            failures++;
            $display("FAIL bp_drop_cnt: drop=%0d required 10", stat_drop_cnt);
        end
        m_axis_tready = 1'b1;
        cyc();
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {16'd1, 16'd55}) begin
            failures++;
            $display("FAIL bp_release: tvalid=%0b tdata=%h required tvalid=1 tdata=%h",
                     m_axis_tvalid, m_axis_tdata, {16'd1, 16'd55});
        end
        checks++;
        if (stat_sample_cnt !== 32'd1) begin
            failures++;
            $display("FAIL bp_samples: samp=%0d required 1", stat_sample_cnt);
        end
    endtask

    task automatic test_frame();
        logic [5:0] got;
        do_reset();
        ctrl_mode = 2'd0; ctrl_period = 32'd1; ctrl_step = 16'd1;
        ctrl_frame_len = 32'd3; m_axis_tready = 1'b1; ctrl_enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            got[i] = m_axis_tlast;
        end
        checks++;
        if (got !== 6'b100100) begin
            failures++;
            $display("FAIL frame_len3: tlast(first..last)=%b required %b",
                     {got[0], got[1], got[2], got[3], got[4], got[5]}, 6'b001001);
        end
        ctrl_frame_len = 32'd0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            got[i] = m_axis_tlast;
        end
        checks++;
        if (got !== 6'b000000) begin
            failures++;
            $display("FAIL frame_len0: tlast=%b required 000000", got);
        end
    endtask

    task automatic test_lfsr();
        logic [15:0] exp_d [3];
        exp_d[0] = 16'hACE1; exp_d[1] = 16'hE270; exp_d[2] = 16'h7138;
        do_reset();
        ctrl_mode = 2'd2; ctrl_period = 32'd1;
        m_axis_tready = 1'b1; ctrl_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {16'(k), exp_d[k]}) begin
                failures++;
                $display("FAIL lfsr_sample[%0d]: tvalid=%0b tdata=%h required tvalid=1 tdata=%h",
                         k, m_axis_tvalid, m_axis_tdata, {16'(k), exp_d[k]});
            end
        end
        checks++;
        if (stat_sample_cnt !== 32'd2) begin
            failures++;
            $display("FAIL lfsr_samples: samp=%0d required 2", stat_sample_cnt);
        end
    endtask

    task automatic test_disable();
        do_reset();
        ctrl_mode = 2'd0; ctrl_period = 32'd1; ctrl_step = 16'd7;
        m_axis_tready = 1'b0; ctrl_enable = 1'b1;
        cyc();
        ctrl_enable = 1'b0;
        cyc();
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0 || stat_drop_cnt !== 32'd0) begin
            failures++;
            $display("FAIL dis_pending: tvalid=%0b tdata=%h drop=%0d required 1/00000000/0",
                     m_axis_tvalid, m_axis_tdata, stat_drop_cnt);
        end
        m_axis_tready = 1'b1;
        repeat (4) cyc();
        checks++;
        if (m_axis_tvalid !== 1'b0 || stat_sample_cnt !== 32'd1) begin
            failures++;
            $display("FAIL dis_drain: tvalid=%0b samp=%0d required 0/1", m_axis_tvalid, stat_sample_cnt);
        end
        ctrl_enable = 1'b1;
        cyc();
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {16'd1, 16'd7}) begin
            failures++;
            $display("FAIL dis_resume: tvalid=%0b tdata=%h required tvalid=1 tdata=%h",
                     m_axis_tvalid, m_axis_tdata, {16'd1, 16'd7});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ctrl_mode = 2'd2; ctrl_period = 32'd1;
        m_axis_tready = 1'b1; ctrl_enable = 1'b1;
        repeat (3) cyc();
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0) begin
            failures++;
            $display("FAIL areset_immediate: tvalid=%0b tdata=%h required 0/00000000", m_axis_tvalid, m_axis_tdata);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        cyc();
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {16'd0, 16'hACE1}) begin
            failures++;
            $display("FAIL areset_restart: tvalid=%0b tdata=%h required tvalid=1 tdata=0000ace1",
                     m_axis_tvalid, m_axis_tdata);
        end
    endtask

`ifdef DUMMY_ADC_SRC_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [31:0] ts [3];
        int          n;
        do_reset();
        ctrl_mode = 2'd0; ctrl_period = 32'd5; ctrl_step = 16'd1;
        m_axis_tready = 1'b1; ctrl_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                cyc();
                n++;
            end while (m_axis_tvalid !== 1'b1 && n < 20);
            ts[k] = m_axis_tuser;
            checks++;
            if (m_axis_tvalid !== 1'b1) begin
                failures++;
                $display("FAIL ts_timeout[%0d]: no tvalid within 20 cycles", k);
            end
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (ts[k] - ts[k-1] !== 32'd5) begin
                failures++;
                $display("FAIL ts_delta[%0d]: delta=%0d required 5", k, ts[k] - ts[k-1]);
            end
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_frame();
        test_lfsr();
        test_disable();
        test_async_reset();
`ifdef DUMMY_ADC_SRC_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
